cordic_scheduler: RTL and testbench
===================================

Name: cordic_scheduler

Overview:
- Shares one fixed-latency sine_cosine CORDIC pipeline between NREQ sun-sensor angle requesters.
- Arbitrates round-robin and issues one angle per cycle with gain-compensated Xin/Yin.
- Tracks every issued request through the pipeline with a valid+ID shift register, then returns registered cos/sin results tagged with the requester ID.
- Sits between the sensor channel front-ends and the CORDIC instance; the CORDIC is instantiated outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, CORDIC data width (c_parameter of the CORDIC)
LATENCY, 16, CORDIC input-register-to-Xout/Yout latency in clocks (equals STG)
GAIN_X, 19898, Xin constant = round((2^(W-1)-1)*0.607253); Yin is always 0
IDW, 2, requester ID width, ceil(log2(NREQ)), minimum 1

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous: drop all in-flight results
req_valid  in  NREQ  per-requester request valid
req_angle  in  32*NREQ  packed angles; requester i occupies [32*i+31:32*i], unsigned 2^32 = 2*pi
req_ready  out  NREQ  one-hot grant; the handshake completes when valid and ready are both high at a rising edge
cordic_angle  out  32  registered angle to the CORDIC
cordic_xin  out  W  registered, GAIN_X on issue
cordic_yin  out  W  registered, always 0
cordic_xout  in  W+1  CORDIC X output (cos)
cordic_yout  in  W+1  CORDIC Y output (sin)
res_valid  out  1  one-cycle result strobe
res_id  out  IDW  requester ID of the result
res_cos  out  W+1  registered cos
res_sin  out  W+1  registered sin
inflight_cnt  out  ceil(log2(LATENCY+2))+1  accepted requests not yet returned

Behaviour:
Reset (reset_n low, asynchronous):
- All outputs are 0.
- Round-robin pointer is 0 and all tag-pipeline valids are cleared.
- Requests in flight at reset are lost and never produce res_valid, even though the unreset CORDIC still flushes out data.

Arbiter:
- Combinational. A requester is eligible when its req_valid is high and flush is low.
- Grant goes to the first eligible index at or after the pointer, searching upward mod NREQ. req_ready is one-hot or all zero.
- req_ready depends combinationally on req_valid, so requesters must not make req_valid depend on req_ready.
- On a grant to i, the pointer becomes (i+1) mod NREQ at the edge. With no grant, the pointer holds.
- flush high forces req_ready to 0.

Issue:
- On an accept at edge N, these registers load: cordic_angle = req_angle[i], cordic_xin = GAIN_X, cordic_yin = 0.
- At the same edge, tag stage 0 loads {valid=1, id=i}.
- With no accept: cordic_angle, cordic_xin and cordic_yin hold their values, and tag stage 0 loads valid=0.
- The angle passes unmodified; the CORDIC does the quadrant pre-rotation.

Tag pipeline and result capture:
- The tag pipeline has LATENCY+1 stages and shifts every cycle; it never stalls.
- The CORDIC samples at N+1 and its Xout/Yout are valid after edge N+LATENCY.
- At edge N+LATENCY+1, res_cos/res_sin load cordic_xout/cordic_yout, res_id loads the tag ID, and res_valid = 1.
- res_valid is high for exactly one cycle per accepted request, and results return in issue order.
- Total latency from accept edge to res_valid is LATENCY+1 edges.
- Back-to-back accepts give back-to-back res_valid.
- When res_valid is 0, res_cos, res_sin and res_id hold their previous values.
- The result interface has no backpressure; consumers must always accept.

flush:
- At an edge with flush high, every tag-stage valid is cleared, no new accept happens, and res_valid is 0 in the following cycle.
- inflight_cnt becomes 0 at that edge.
- The pointer is unchanged.

inflight_cnt:
- +1 on accept, -1 on an edge that asserts res_valid.
- An accept and a return on the same edge leave it unchanged.
- Maximum value is LATENCY+1 (continuous issue); it never wraps.

Width rule: the CORDIC outputs are W+1-bit signed and are passed through without truncation or saturation.

Test Plan:
- Reset mid-stream: 5 accepts, reset_n pulsed low 2 cycles later -> all outputs 0 immediately, no res_valid during the next 40 cycles, inflight_cnt=0.
- Single request: req 2 with angle 0x00000000 accepted at edge N -> res_valid only in the cycle after edge N+17, res_id=2, res_cos=32767±8, res_sin=0±8.
- Quadrant values: angles 0x20000000, 0x40000000, 0xC0000000 on req 0 -> cos/sin = 23170/23170, 0/32767, 0/-32767, each ±8; returned in order on consecutive cycles.
- Round-robin fairness: all 4 req_valid held high 12 cycles from pointer 0 -> grant order 0,1,2,3 repeating; 12 contiguous res_valid with IDs 0,1,2,3,...; inflight_cnt peaks at 12.
- Sparse fairness: only req 1 and req 3 valid, continuously -> grants alternate 1,3,1,3; req 0 and req 2 never granted.
- Flush: 6 accepts, then flush high for 1 cycle at the 3rd cycle after the last accept -> no res_valid from those 6, inflight_cnt=0 after the flush edge, req_ready all 0 during flush; a request accepted on the next cycle returns normally 17 edges later.

Source files
------------

// File: rtl/cordic_scheduler.sv
// Round-robin front end that time-shares one fixed-latency sine/cosine CORDIC
// between NREQ angle requesters and tags each result with its requester ID.
module cordic_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int LATENCY = 16,
  parameter int GAIN_X  = 19898,
  parameter int IDW     = 2,
  localparam int CW     = $clog2(LATENCY + 2) + 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [32*NREQ-1:0]     req_angle,
  output logic [NREQ-1:0]        req_ready,
  output logic [31:0]            cordic_angle,
  output logic [W-1:0]           cordic_xin,
  output logic [W-1:0]           cordic_yin,
  input  logic signed [W:0]      cordic_xout,
  input  logic signed [W:0]      cordic_yout,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic signed [W:0]      res_cos,
  output logic signed [W:0]      res_sin,
  output logic [CW-1:0]          inflight_cnt
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gid;
  logic [IDW-1:0] idx;
  logic           accept;
  logic           ret;
  logic [NREQ-1:0] grant;

  // Tag stage k holds the request accepted k edges earlier; the last stage
  // lines up with the CORDIC output being valid.
  logic [LATENCY:0] tag_valid;
  logic [IDW-1:0]   tag_id [LATENCY+1];

  always_comb begin
    grant  = '0;
    gid    = '0;
    idx    = '0;
    accept = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!accept && !flush && req_valid[idx]) begin
        accept     = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
  end

  assign req_ready = grant;
  assign ret       = tag_valid[LATENCY] && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      cordic_angle <= '0;
      cordic_xin   <= '0;
      cordic_yin   <= '0;
      tag_valid    <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_id[k] <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_cos      <= '0;
      res_sin      <= '0;
      inflight_cnt <= '0;
    end else begin
      if (accept) begin
        ptr          <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
        cordic_angle <= req_angle[32*gid +: 32];
        cordic_xin   <= W'(GAIN_X);
        cordic_yin   <= '0;
      end

      tag_id[0] <= gid;
      for (int k = 1; k <= LATENCY; k++) tag_id[k] <= tag_id[k-1];
      if (flush) tag_valid <= '0;
      else       tag_valid <= {tag_valid[LATENCY-1:0], accept};

      res_valid <= ret;
      if (ret) begin
        res_id  <= tag_id[LATENCY];
        res_cos <= cordic_xout;
        res_sin <= cordic_yout;
      end

      if (flush)               inflight_cnt <= '0;
      else if (accept && !ret) inflight_cnt <= inflight_cnt + CW'(1);
      else if (!accept && ret) inflight_cnt <= inflight_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: behavioural CORDIC stand-in, queue-based
// scoreboard of issued requests, directed scenarios then random traffic.
module tb_cordic_scheduler;
  localparam int NREQ = 4, W = 16, LATENCY = 16, GAIN_X = 19898, IDW = 2;
  localparam int CW = $clog2(LATENCY + 2) + 1;

  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [32*NREQ-1:0] req_angle = '0;
  logic [NREQ-1:0] req_ready;
  logic [31:0] cordic_angle;
  logic [W-1:0] cordic_xin, cordic_yin;
  logic signed [W:0] cordic_xout, cordic_yout;
  logic res_valid;
  logic [IDW-1:0] res_id;
  logic signed [W:0] res_cos, res_sin;
  logic [CW-1:0] inflight_cnt;

  always #5 clock = ~clock;

  cordic_scheduler #(.NREQ(NREQ), .W(W), .LATENCY(LATENCY), .GAIN_X(GAIN_X), .IDW(IDW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .req_valid(req_valid),
    .req_angle(req_angle), .req_ready(req_ready), .cordic_angle(cordic_angle),
    .cordic_xin(cordic_xin), .cordic_yin(cordic_yin), .cordic_xout(cordic_xout),
    .cordic_yout(cordic_yout), .res_valid(res_valid), .res_id(res_id),
    .res_cos(res_cos), .res_sin(res_sin), .inflight_cnt(inflight_cnt));

  // Ideal rotation of (xin, 0) by the angle, with the CORDIC gain removed.
  function automatic logic signed [W:0] cs(input logic [31:0] a, input logic [W-1:0] x, input bit sn);
    real th, m, r;
    th = 6.283185307179586 * (real'(a) / 4294967296.0);
    m  = real'(x) / 0.607253;
    r  = sn ? m * $sin(th) : m * $cos(th);
    r  = (r >= 0.0) ? r + 0.5 : r - 0.5;
    return (W+1)'($rtoi(r));
  endfunction

  // Unreset CORDIC stand-in: samples at each edge, output valid LATENCY-1 edges later.
  logic signed [W:0] cx_pipe [LATENCY];
  logic signed [W:0] cy_pipe [LATENCY];
  always @(posedge clock) begin
    cx_pipe[0] <= cs(cordic_angle, cordic_xin, 1'b0);
    cy_pipe[0] <= cs(cordic_angle, cordic_xin, 1'b1);
    for (int k = 1; k < LATENCY; k++) begin
      cx_pipe[k] <= cx_pipe[k-1];
      cy_pipe[k] <= cy_pipe[k-1];
    end
  end
  assign cordic_xout = cx_pipe[LATENCY-1];
  assign cordic_yout = cy_pipe[LATENCY-1];

  typedef struct {int due; int id; logic [31:0] ang;} sb_t;
  sb_t q[$];
  int checks = 0, errors = 0, cyc = 0, m_ptr = 0, m_inflight = 0, peak = 0;
  logic [IDW-1:0] m_rid = '0;
  logic signed [W:0] m_rcos = '0, m_rsin = '0;
  logic [31:0] m_angle = '0;
  logic [W-1:0] m_xin = '0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tol(input string tag, input logic signed [W:0] obs, input int exp);
    int d;
    d = int'(obs) - exp;
    checks++;
    assert (((d <= 8) && (d >= -8)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-8", tag, obs, exp);
    end
  endtask

  function automatic logic [32*NREQ-1:0] rand_angles();
    logic [32*NREQ-1:0] a;
    for (int i = 0; i < NREQ; i++) a[32*i +: 32] = $urandom;
    return a;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 0; m_inflight = 0; m_rid = '0; m_rcos = '0; m_rsin = '0;
    m_angle = '0; m_xin = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_angle"}, cordic_angle, 0);
    chk({tag, "_xin"}, cordic_xin, 0);
    chk({tag, "_yin"}, cordic_yin, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_cos"}, res_cos, 0);
    chk({tag, "_res_sin"}, res_sin, 0);
    chk({tag, "_inflight"}, inflight_cnt, 0);
  endtask

  // One clock: drive, check grant, clock, advance the reference model, check outputs.
  task automatic step(input logic [NREQ-1:0] v, input logic fl, input logic [32*NREQ-1:0] ang);
    int g;
    bit ev;
    logic [NREQ-1:0] eg;
    sb_t e;
    @(negedge clock);
    req_valid = v; flush = fl; req_angle = ang;
    #1;
    g = -1; eg = '0;
    if (!fl)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", req_ready, eg);
    @(posedge clock);
    cyc++;
    ev = 1'b0;
    if (fl) begin
      q.delete();
      m_inflight = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        ev = 1'b1;
        m_rid = IDW'(e.id);
        m_rcos = cs(e.ang, W'(GAIN_X), 1'b0);
        m_rsin = cs(e.ang, W'(GAIN_X), 1'b1);
      end
      if (g >= 0) begin
        q.push_back('{due: cyc + LATENCY + 1, id: g, ang: ang[32*g +: 32]});
        m_ptr = (g + 1) % NREQ;
        m_angle = ang[32*g +: 32];
        m_xin = W'(GAIN_X);
      end
      m_inflight = m_inflight + ((g >= 0) ? 1 : 0) - (ev ? 1 : 0);
    end
    #1;
    chk("res_valid", res_valid, ev);
    chk("res_id", res_id, m_rid);
    chk("res_cos", res_cos, m_rcos);
    chk("res_sin", res_sin, m_rsin);
    chk("inflight_cnt", inflight_cnt, m_inflight);
    chk("cordic_angle", cordic_angle, m_angle);
    chk("cordic_xin", cordic_xin, m_xin);
    chk("cordic_yin", cordic_yin, 0);
    if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, rand_angles());
  endtask

  initial begin
    logic [32*NREQ-1:0] a;

    // Power-on reset
    #2;
    check_all_zero("por");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Single request on requester 2 at angle 0
    a = rand_angles();
    a[64 +: 32] = 32'h0;
    step(4'b0100, 1'b0, a);
    idle(16);
    chk("single_early", q.size(), 1);
    step('0, 1'b0, rand_angles());
    chk("single_valid", res_valid, 1);
    chk("single_id", res_id, 2);
    tol("single_cos", res_cos, 32767);
    tol("single_sin", res_sin, 0);
    idle(2);

    // Quadrant angles on requester 0, back to back
    a = rand_angles(); a[31:0] = 32'h2000_0000; step(4'b0001, 1'b0, a);
    a = rand_angles(); a[31:0] = 32'h4000_0000; step(4'b0001, 1'b0, a);
    a = rand_angles(); a[31:0] = 32'hC000_0000; step(4'b0001, 1'b0, a);
    idle(14);
    step('0, 1'b0, rand_angles());
    tol("q45_cos", res_cos, 23170); tol("q45_sin", res_sin, 23170);
    step('0, 1'b0, rand_angles());
    tol("q90_cos", res_cos, 0); tol("q90_sin", res_sin, 32767);
    step('0, 1'b0, rand_angles());
    chk("q270_valid", res_valid, 1);
    tol("q270_cos", res_cos, 0); tol("q270_sin", res_sin, -32767);
    idle(2);

    // Reset mid-stream: in-flight requests must never return
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, rand_angles());
    idle(2);
    @(negedge clock);
    req_valid = '0; flush = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(40);

    // Round robin from pointer 0 with all requesters busy
    peak = 0;
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, rand_angles());
    idle(20);
    chk("rr_peak", peak, 12);

    // Sparse fairness: only requesters 1 and 3
    for (int i = 0; i < 8; i++) step(4'b1010, 1'b0, rand_angles());
    idle(20);

    // Flush three cycles after the sixth accept
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, rand_angles());
    idle(2);
    step(4'b1111, 1'b1, rand_angles());
    chk("flush_inflight", inflight_cnt, 0);
    step(4'b0010, 1'b0, rand_angles());
    idle(17);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(NREQ'($urandom), ($urandom_range(0, 19) == 0), rand_angles());
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
